seg7_scan_ctrl: RTL

//  Multiplexed scan controller for the 8-digit seven-segment display, driven through two cascaded 74HC595s on seg7_SH_CP/ST_CP/DS.

---
 rtl/seg7_pkg.sv | 20 ++
 rtl/seg7_hex_decode.sv | 15 +
 rtl/seg7_scan_ctrl.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/seg7_pkg.sv
// Shared types and constants for the 8-digit seven-segment scan controller.
package seg7_pkg;

  localparam int SEG7_DIGITS = 8;

  // Segment bytes {dp,g,f,e,d,c,b,a} for hex 0..F, active-high, dp clear.
  localparam logic [7:0] SEG7_HEX_SEG [16] = '{
    8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
    8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71
  };

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SHIFT,
    LATCH,
    HOLD
  } seg7_state_t;

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational digit code {blank,dp,hex[3:0]} to active-high segment byte.
module seg7_hex_decode
  import seg7_pkg::*;
(
  input  logic [5:0] code,
  output logic [7:0] seg
);

  always_comb begin
    seg    = SEG7_HEX_SEG[code[3:0]];
    seg[7] = code[4];
    if (code[5]) seg = 8'h00;
  end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Round-robin scan of 8 digit codes out through two cascaded 74HC595s.
//  state | meaning
//  IDLE  | serial lines low, waiting for enable
//  LOAD  | capture {seg,sel} word of digit idx into the shift register
//  SHIFT | 16 bits MSB first, SH_CP low then high for CLK_DIV cycles each
//  LATCH | ST_CP high then low for CLK_DIV cycles each
//  HOLD  | display for HOLD_CYC cycles, then advance idx
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int CLK_DIV        = 4,
  parameter int HOLD_CYC       = 100000,
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int SEL_ACTIVE_LOW = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       wr_en,
  input  logic [2:0] wr_addr,
  input  logic [5:0] wr_data,
  output logic       busy,
  output logic       frame_done,
  output logic       seg7_SH_CP,
  output logic       seg7_ST_CP,
  output logic       seg7_DS
);

  localparam int PH_W   = ($clog2(CLK_DIV) > 0) ? $clog2(CLK_DIV) : 1;
  localparam int HOLD_W = ($clog2(HOLD_CYC) > 0) ? $clog2(HOLD_CYC) : 1;
  localparam logic [PH_W-1:0]   PH_LAST   = PH_W'(CLK_DIV - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYC - 1);

  seg7_state_t       state;
  logic [2:0]        idx;
  logic [15:0]       sr;
  logic [3:0]        bit_cnt;
  logic [PH_W-1:0]   phase_cnt;
  logic              phase_hi;
  logic [HOLD_W-1:0] hold_cnt;
  logic [5:0]        digit_reg [SEG7_DIGITS];

  logic [7:0] seg_raw;
  logic [7:0] seg_byte;
  logic [7:0] sel_onehot;
  logic [7:0] sel_byte;

  seg7_hex_decode u_decode (
    .code (digit_reg[idx]),
    .seg  (seg_raw)
  );

  assign seg_byte   = (SEG_ACTIVE_LOW != 0) ? ~seg_raw : seg_raw;
  assign sel_onehot = 8'd1 << idx;
  assign sel_byte   = (SEL_ACTIVE_LOW != 0) ? ~sel_onehot : sel_onehot;

  // Writes land immediately; the FSM only samples a digit on its LOAD cycle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < SEG7_DIGITS; i++) digit_reg[i] <= 6'b100000;
    end else if (wr_en) begin
      digit_reg[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      idx        <= '0;
      sr         <= '0;
      bit_cnt    <= '0;
      phase_cnt  <= '0;
      phase_hi   <= 1'b0;
      hold_cnt   <= '0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      seg7_SH_CP <= 1'b0;
      seg7_ST_CP <= 1'b0;
      seg7_DS    <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          seg7_SH_CP <= 1'b0;
          seg7_ST_CP <= 1'b0;
          seg7_DS    <= 1'b0;
          if (enable) begin
            state <= LOAD;
            busy  <= 1'b1;
          end else begin
            busy  <= 1'b0;
          end
        end
        LOAD: begin
          sr         <= {seg_byte, sel_byte};
          seg7_DS    <= seg_byte[7];
          seg7_SH_CP <= 1'b0;
          bit_cnt    <= 4'd15;
          phase_cnt  <= PH_LAST;
          phase_hi   <= 1'b0;
          state      <= SHIFT;
        end
        SHIFT: begin
          if (phase_cnt != '0) begin
            phase_cnt <= phase_cnt - 1'b1;
          end else if (!phase_hi) begin
            seg7_SH_CP <= 1'b1;
            phase_hi   <= 1'b1;
            phase_cnt  <= PH_LAST;
          end else begin
            // SH_CP falling edge: present the next bit, or start the latch pulse
            seg7_SH_CP <= 1'b0;
            phase_hi   <= 1'b0;
            phase_cnt  <= PH_LAST;
            if (bit_cnt == '0) begin
              seg7_DS    <= 1'b0;
              seg7_ST_CP <= 1'b1;
              state      <= LATCH;
            end else begin
              sr      <= {sr[14:0], 1'b0};
              seg7_DS <= sr[14];
              bit_cnt <= bit_cnt - 4'd1;
            end
          end
        end
        LATCH: begin
          if (phase_cnt != '0) begin
            phase_cnt <= phase_cnt - 1'b1;
          end else if (!phase_hi) begin
            seg7_ST_CP <= 1'b0;
            phase_hi   <= 1'b1;
            phase_cnt  <= PH_LAST;
          end else begin
            phase_hi <= 1'b0;
            hold_cnt <= HOLD_LAST;
            state    <= HOLD;
          end
        end
        HOLD: begin
          if (hold_cnt != '0) begin
            hold_cnt <= hold_cnt - 1'b1;
          end else begin
            idx        <= idx + 3'd1;
            frame_done <= (idx == 3'd7);
            if (enable) begin
              state <= LOAD;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
